mem_responder_8051: RTL

Memory-side responder for the 8051 cache controller. It accepts single-byte read (miss refill) and write requests on a valid/ready request channel and services them from an internal byte-wide RAM after a programmable number of wait states. It returns read data, and optionally write acknowledges, on a valid/ready response channel. It sits between the cache controller's miss/write port and the rest of the memory map. Addresses outside the implemented RAM return an error flag and the fill pattern.

---
 rtl/mem_responder_8051_if.sv | 29 ++
 rtl/mem_responder_8051.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_responder_8051_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder_8051_if                                                |
// | Request/response bus between the 8051 cache controller (master) and  |
// | the memory-side responder (slave).                                   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface mem_responder_8051_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder_8051.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder_8051                                                   |
// | Single-outstanding byte memory responder with programmable wait      |
// | states. Out-of-range addresses return FILL_BYTE with an error flag.  |
// | Optional feature macro: MEM_WR_ACK_EN (writes return a response).    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_responder_8051 #(
  parameter int          MEM_AW    = 10,
  parameter int          LATENCY   = 2,
  parameter logic [7:0]  FILL_BYTE = 8'hAB
) (
  input wire                   clk,
  input wire                   rst_n,
  mem_responder_8051_if.slave  bus
);

  localparam logic [3:0] C_LATENCY = 4'(LATENCY);
`ifdef MEM_WR_ACK_EN
  localparam logic       C_WR_ACK  = 1'b1;
`else
  localparam logic       C_WR_ACK  = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_accept;
  logic        w_commit;
  logic        w_in_range;
  logic [MEM_AW-1:0] w_idx;
  logic [7:0]  w_rd_byte;

  logic        r_req_ready;
  logic        r_we;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [3:0]  r_cnt;
  logic        r_done;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_data;
  logic        r_rsp_err;

  logic [7:0]  r_mem [0:(1<<MEM_AW)-1];

  // Range check on the latched address; a full 16-bit RAM has no hole.
  generate
    if (MEM_AW >= 16) begin : g_full_range
      assign w_in_range = 1'b1;
    end else begin : g_part_range
      assign w_in_range = (r_addr[15:MEM_AW] == '0);
    end
  endgenerate

  assign w_idx     = r_addr[MEM_AW-1:0];
  assign w_rd_byte = r_mem[w_idx];
  // req_ready is registered so it stays low throughout reset.
  assign w_accept  = bus.req_valid && r_req_ready;

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. RESP spends its first cycle committing the access
  // (w_commit) so the response appears LATENCY+1 cycles after acceptance.
  always_comb begin
    w_next_state = r_state;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = (C_LATENCY == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (!r_done) begin
          w_commit = 1'b1;
        end else if ((r_we && !C_WR_ACK) || bus.rsp_ready) begin
          // Unacknowledged writes leave without a handshake.
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 16'h0000;
      r_wdata     <= 8'h00;
      r_cnt       <= 4'd0;
      r_done      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= (w_next_state == S_IDLE);
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_cnt   <= C_LATENCY;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_done      <= 1'b1;
        r_rsp_err   <= !w_in_range;
        r_rsp_valid <= !r_we || C_WR_ACK;
        if (r_we) begin
          r_rsp_data <= 8'h00;
        end else if (w_in_range) begin
          r_rsp_data <= w_rd_byte;
        end else begin
          r_rsp_data <= FILL_BYTE;
        end
      end else if ((r_state == S_RESP) && (w_next_state == S_IDLE)) begin
        r_done      <= 1'b0;
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // RAM write port; contents survive reset and are undefined until written.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && w_in_range) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

endmodule
`default_nettype wire
